// File: rtl/sbox_hpc1_share_driver_d2.sv
// Host-side driver for the 3-share HPC1 clock-gated S-box core: takes one share
// triple plus one fresh-randomness word, runs a single core evaluation, and
// returns the captured result shares. Shares are only ever moved, never combined.
module sbox_hpc1_share_driver_d2 #(
    parameter int unsigned LATENCY = 11,
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned RND_W   = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_s0,
    input  logic [3:0]       in_s1,
    input  logic [3:0]       in_s2,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    input  logic [RND_W-1:0] rnd_in,
    output logic             core_rst,
    output logic [3:0]       SI_s0,
    output logic [3:0]       SI_s1,
    output logic [3:0]       SI_s2,
    output logic [RND_W-1:0] Fresh,
    input  logic [3:0]       SO_s0,
    input  logic [3:0]       SO_s1,
    input  logic [3:0]       SO_s2,
    input  logic             Synch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_s0,
    output logic [3:0]       out_s1,
    output logic [3:0]       out_s2,
    output logic             err_timeout,
    output logic             err_early
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               core_rst_q, core_rst_d;
    logic               err_early_q, err_early_d;
    logic               err_timeout_q, err_timeout_d;
    logic [NIB_W-1:0]   si0_q, si1_q, si2_q;
    logic [RND_W-1:0]   fresh_q;
    logic [NIB_W-1:0]   out0_q, out1_q, out2_q;
    logic               accept;
    logic               capture;
    logic               cnt_at_limit;

    // Both sources must be valid on the same edge; nothing is consumed otherwise.
    assign accept       = (state_q == ST_IDLE) && in_ready_q && in_valid && rnd_valid;
    assign capture      = (state_q == ST_WAIT) && Synch;
    assign cnt_at_limit = (cnt_q == CNT_W'(TIMEOUT));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (Synch)             state_d = ST_OUT;
                else if (cnt_at_limit) state_d = ST_IDLE;
            end
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered control outputs, counter and sticky flags.
    always_comb begin
        cnt_d         = '0;
        in_ready_d    = (state_d == ST_IDLE);
        out_valid_d   = (state_d == ST_OUT);
        core_rst_d    = (state_d != ST_WAIT);
        err_early_d   = err_early_q;
        err_timeout_d = err_timeout_q;
        unique case (state_q)
            ST_LOAD: cnt_d = CNT_W'(1);
            ST_WAIT: begin
                if (state_d == ST_WAIT)
                    cnt_d = cnt_at_limit ? cnt_q : cnt_q + CNT_W'(1);
                if (capture && (cnt_q < CNT_W'(LATENCY)))
                    err_early_d = 1'b1;
                if (!Synch && cnt_at_limit)
                    err_timeout_d = 1'b1;
            end
            default: cnt_d = '0;
        endcase
    end

    // Control registers; core_rst is held high throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            core_rst_q    <= 1'b1;
            err_early_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            core_rst_q    <= core_rst_d;
            err_early_q   <= err_early_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Share/randomness registers: SI and Fresh change only on accept, outputs only on Synch capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            si0_q   <= '0;
            si1_q   <= '0;
            si2_q   <= '0;
            fresh_q <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
        end else begin
            if (accept) begin
                si0_q   <= in_s0;
                si1_q   <= in_s1;
                si2_q   <= in_s2;
                fresh_q <= rnd_in;
            end
            if (capture) begin
                out0_q <= SO_s0;
                out1_q <= SO_s1;
                out2_q <= SO_s2;
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign rnd_ready   = accept;
    assign core_rst    = core_rst_q;
    assign SI_s0       = si0_q;
    assign SI_s1       = si1_q;
    assign SI_s2       = si2_q;
    assign Fresh       = fresh_q;
    assign out_valid   = out_valid_q;
    assign out_s0      = out0_q;
    assign out_s1      = out1_q;
    assign out_s2      = out2_q;
    assign err_timeout = err_timeout_q;
    assign err_early   = err_early_q;

endmodule

// File: tb/tb_sbox_hpc1_share_driver_d2.sv
// Directed-plus-random bench for sbox_hpc1_share_driver_d2 with a behavioural
// model of the masked S-box core on the other side of the share interface.
module tb_sbox_hpc1_share_driver_d2;

    localparam int LAT = 11;
    localparam int TMO = 32;
    localparam int RW  = 65;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [3:0]    in_s0, in_s1, in_s2;
    logic          rnd_valid, rnd_ready;
    logic [RW-1:0] rnd_in;
    logic          core_rst;
    logic [3:0]    SI_s0, SI_s1, SI_s2;
    logic [RW-1:0] Fresh;
    logic [3:0]    SO_s0, SO_s1, SO_s2;
    logic          Synch;
    logic          out_valid, out_ready;
    logic [3:0]    out_s0, out_s1, out_s2;
    logic          err_timeout, err_early;

    sbox_hpc1_share_driver_d2 dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_in(rnd_in),
        .core_rst(core_rst),
        .SI_s0(SI_s0), .SI_s1(SI_s1), .SI_s2(SI_s2), .Fresh(Fresh),
        .SO_s0(SO_s0), .SO_s1(SO_s1), .SO_s2(SO_s2), .Synch(Synch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2),
        .err_timeout(err_timeout), .err_early(err_early)
    );

    always #5 clk = ~clk;

    // Skinny 4-bit S-box
    logic [3:0] sbox_tbl [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                  4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};

    int tests = 0;
    int fails = 0;

    // core model controls / record of the shares it returned
    int         synch_at    = LAT;   // 0 = never assert Synch
    logic       extra_synch = 1'b0;
    logic [3:0] last_so0 = '0, last_so1 = '0, last_so2 = '0;

    // bench-side expectations
    logic [3:0]    prev_si0 = '0, prev_si1 = '0, prev_si2 = '0;
    logic [RW-1:0] prev_w   = '0;
    logic          exp_early = 1'b0, exp_to = 1'b0;
    int            cyc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Core model: counts cycles since its clock-gating reset was released and
    // returns a fresh random 3-share split of S(x) when the count hits synch_at.
    initial begin : core_model
        int k;
        logic fire;
        logic [3:0] x, r0, r1;
        k = 0;
        Synch = 1'b0;
        SO_s0 = '0; SO_s1 = '0; SO_s2 = '0;
        forever begin
            @(negedge clk);
            if (core_rst === 1'b1) k = 0;
            else k++;
            fire = (synch_at != 0) && (k == synch_at) && (core_rst === 1'b0);
            if (fire) begin
                x  = SI_s0 ^ SI_s1 ^ SI_s2;
                r0 = 4'($urandom);
                r1 = 4'($urandom);
                SO_s0 = r0;
                SO_s1 = r1;
                SO_s2 = sbox_tbl[x] ^ r0 ^ r1;
                last_so0 = SO_s0; last_so1 = SO_s1; last_so2 = SO_s2;
            end else begin
                SO_s0 = 4'($urandom);
                SO_s1 = 4'($urandom);
                SO_s2 = 4'($urandom);
            end
            Synch = fire || extra_synch;
        end
    end

    // Present shares (optionally withholding randomness for 'gate' cycles) and
    // complete the accept; returns at the negedge of the LOAD cycle (cyc = 1).
    task automatic start_op(input logic [3:0] a0, a1, a2, input logic [RW-1:0] w, input int gate);
        in_s0 = a0; in_s1 = a1; in_s2 = a2; rnd_in = w;
        in_valid = 1'b1;
        rnd_valid = (gate == 0);
        for (int i = 0; i < 64 && in_ready !== 1'b1; i++) @(negedge clk);
        check("in_ready_before_accept", 128'(in_ready), 128'(1));
        for (int i = 0; i < gate; i++) begin
            #1;
            check("gate_rnd_ready", 128'(rnd_ready), 128'(0));
            check("gate_SI_stable", {SI_s0, SI_s1, SI_s2}, {prev_si0, prev_si1, prev_si2});
            check("gate_Fresh_stable", 128'(Fresh), 128'(prev_w));
            @(negedge clk);
            check("gate_in_ready", 128'(in_ready), 128'(1));
        end
        rnd_valid = 1'b1;
        #1;
        check("rnd_ready_on_accept", 128'(rnd_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rnd_valid = 1'b0;
        in_s0 = 4'($urandom); in_s1 = 4'($urandom); in_s2 = 4'($urandom);
        rnd_in = {$urandom, $urandom, $urandom};
        cyc = 1;
        prev_si0 = a0; prev_si1 = a1; prev_si2 = a2; prev_w = w;
        check("SI_latched", {SI_s0, SI_s1, SI_s2}, {a0, a1, a2});
        check("Fresh_latched", 128'(Fresh), 128'(w));
        check("load_core_rst", 128'(core_rst), 128'(1));
        check("load_in_ready", 128'(in_ready), 128'(0));
    endtask

    // Wait for the result, verify timing/shares/flags, hold backpressure, hand off.
    task automatic finish_op(input logic [3:0] v, input int sat, input int hold);
        int first;
        first = -1;
        out_ready = (hold == 0);
        for (cyc = 2; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                first = cyc;
                break;
            end
        end
        check("out_valid_cycle", 128'(first), 128'(sat + 2));
        check("result_sbox", 128'(out_s0 ^ out_s1 ^ out_s2), 128'(sbox_tbl[v]));
        check("result_shares", {out_s0, out_s1, out_s2}, {last_so0, last_so1, last_so2});
        check("SI_held", {SI_s0, SI_s1, SI_s2, Fresh}, {prev_si0, prev_si1, prev_si2, prev_w});
        check("err_early", 128'(err_early), 128'(exp_early));
        check("err_timeout", 128'(err_timeout), 128'(exp_to));
        if (hold > 0) begin
            extra_synch = 1'b1;
            for (int i = 0; i < hold; i++) begin
                check("bp_out_valid", 128'(out_valid), 128'(1));
                check("bp_out_stable", {out_s0, out_s1, out_s2}, {last_so0, last_so1, last_so2});
                check("bp_in_ready", 128'(in_ready), 128'(0));
                @(negedge clk);
            end
            extra_synch = 1'b0;
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("post_hs_out_valid", 128'(out_valid), 128'(0));
        check("post_hs_in_ready", 128'(in_ready), 128'(1));
    endtask

    task automatic full_op(input logic [3:0] v, input int sat, input int gate, input int hold);
        logic [3:0] a0, a1;
        logic [RW-1:0] w;
        a0 = 4'($urandom);
        a1 = 4'($urandom);
        w  = {$urandom, $urandom, $urandom};
        synch_at = sat;
        if (sat < LAT) exp_early = 1'b1;
        start_op(a0, a1, v ^ a0 ^ a1, w, gate);
        finish_op(v, sat, hold);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic saw_ov;
        rst = 1'b1;
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        in_s0 = 4'h1; in_s1 = 4'h2; in_s2 = 4'h3; rnd_in = '1;
        repeat (3) @(negedge clk);
        #1;
        // reset values
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_rnd_ready", 128'(rnd_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_core_rst", 128'(core_rst), 128'(1));
        check("rst_SI_Fresh", {SI_s0, SI_s1, SI_s2, Fresh}, 128'(0));
        check("rst_out", {out_s0, out_s1, out_s2}, 128'(0));
        check("rst_errs", {err_early, err_timeout}, 128'(0));
        in_valid = 1'b0; rnd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // nominal: value 0xC split as 5/A/3, out_ready high
        synch_at = LAT;
        start_op(4'h5, 4'hA, 4'h3, {$urandom, $urandom, $urandom}, 0);
        finish_op(4'hC, LAT, 0);

        // handshake gating: randomness withheld for 5 cycles
        full_op(4'h7, LAT, 5, 0);

        // backpressure with stray Synch pulses while holding the result
        full_op(4'h2, LAT, 0, 20);

        // early Synch at cnt=4: flagged but delivered
        full_op(4'h9, 4, 0, 0);

        // timeout: core never answers
        synch_at = 0;
        start_op(4'h1, 4'h4, 4'h8, {$urandom, $urandom, $urandom}, 0);
        saw_ov = 1'b0;
        for (cyc = 2; cyc <= TMO + 1; cyc++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_ov = 1'b1;
        end
        check("to_no_out_valid", 128'(saw_ov), 128'(0));
        check("to_flag_before", 128'(err_timeout), 128'(0));
        check("to_in_ready_before", 128'(in_ready), 128'(0));
        @(negedge clk);
        exp_to = 1'b1;
        check("to_flag_set", 128'(err_timeout), 128'(1));
        check("to_back_idle", 128'(in_ready), 128'(1));
        check("to_out_valid", 128'(out_valid), 128'(0));

        // operation after timeout still works
        full_op(4'hE, LAT, 0, 0);

        // async reset while waiting at cnt=6
        synch_at = LAT;
        start_op(4'h6, 4'h3, 4'hF, {$urandom, $urandom, $urandom}, 0);
        for (cyc = 2; cyc <= 7; cyc++) @(negedge clk);
        in_valid = 1'b1; rnd_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 128'(in_ready), 128'(0));
        check("mid_rst_rnd_ready", 128'(rnd_ready), 128'(0));
        check("mid_rst_out_valid", 128'(out_valid), 128'(0));
        check("mid_rst_core_rst", 128'(core_rst), 128'(1));
        check("mid_rst_SI_Fresh", {SI_s0, SI_s1, SI_s2, Fresh}, 128'(0));
        check("mid_rst_out", {out_s0, out_s1, out_s2}, 128'(0));
        check("mid_rst_errs", {err_early, err_timeout}, 128'(0));
        in_valid = 1'b0; rnd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_early = 1'b0; exp_to = 1'b0;
        prev_si0 = '0; prev_si1 = '0; prev_si2 = '0; prev_w = '0;

        // every input value, random share splits and randomness
        for (int v = 0; v < 16; v++) full_op(4'(v), LAT, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
